// File: rtl/led_pkg.sv
// led_pkg: shared definitions for the LED trail PWM output stage.
//   - chan_state_t : per-channel fade state (OFF, LIT, FADE)
//   - pwm_max()    : full-scale brightness for a given PWM resolution
//   - DEFAULT_*    : default decay timing (10 ms ticks at 50 MHz, 32 per tick)
package led_pkg;

  typedef enum logic [1:0] {
    ST_OFF  = 2'd0,
    ST_LIT  = 2'd1,
    ST_FADE = 2'd2
  } chan_state_t;

  localparam int DEFAULT_PWM_BITS   = 8;
  localparam int DEFAULT_DECAY_DIV  = 500000;
  localparam int DEFAULT_DECAY_STEP = 32;

  // Full-scale brightness; also the PWM period in clock cycles.
  function automatic int pwm_max(input int bits);
    return (1 << bits) - 1;
  endfunction

endpackage

// File: rtl/led_fade_channel.sv
// led_fade_channel: one LED channel of the trail PWM stage.
// Holds the OFF/LIT/FADE state, the brightness register and the PWM
// comparator that produces the registered LED drive bit.
// Ports:
//   clk, rst_n : clock and asynchronous active-low reset
//   led        : registered pattern bit for this channel
//   trail      : 1 = fade out when the pattern bit drops, 0 = hard off
//   tick       : shared decay tick, one cycle wide
//   pwm_cnt    : shared PWM counter
//   pwm_out    : registered PWM drive for this LED
module led_fade_channel
  import led_pkg::*;
#(
  parameter int PWM_BITS   = DEFAULT_PWM_BITS,
  parameter int DECAY_STEP = DEFAULT_DECAY_STEP
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                led,
  input  logic                trail,
  input  logic                tick,
  input  logic [PWM_BITS-1:0] pwm_cnt,
  output logic                pwm_out
);

  localparam logic [PWM_BITS-1:0] B_MAX  = PWM_BITS'(pwm_max(PWM_BITS));
  localparam logic [PWM_BITS-1:0] B_STEP = PWM_BITS'(DECAY_STEP);

  chan_state_t         state, state_next;
  logic [PWM_BITS-1:0] b, b_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_OFF;
      b       <= '0;
      pwm_out <= 1'b0;
    end else begin
      state   <= state_next;
      b       <= b_next;
      pwm_out <= (pwm_cnt < b);
    end
  end

  // A lit input always wins, then a hard clear when the trail is disabled,
  // and only then the decay. Decay reaching or crossing zero ends in OFF
  // rather than wrapping.
  always_comb begin
    state_next = state;
    b_next     = b;
    if (led) begin
      state_next = ST_LIT;
      b_next     = B_MAX;
    end else begin
      case (state)
        ST_LIT: begin
          if (trail) begin
            state_next = ST_FADE;
          end else begin
            state_next = ST_OFF;
            b_next     = '0;
          end
        end
        ST_FADE: begin
          if (!trail) begin
            state_next = ST_OFF;
            b_next     = '0;
          end else if (tick) begin
            if (b > B_STEP) begin
              b_next = b - B_STEP;
            end else begin
              b_next     = '0;
              state_next = ST_OFF;
            end
          end
        end
        default: begin
          state_next = ST_OFF;
          b_next     = '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/led_trail_pwm.sv
// led_trail_pwm: PWM output stage behind the dioda_2 running light.
// Each LED follows its pattern bit; when a bit drops with iTRAIL=1 the LED
// fades out in DECAY_STEP decrements, one per decay tick (comet trail).
// Ports:
//   iCLK   : system clock
//   iRST_N : asynchronous active-low reset
//   iLED   : LED pattern from dioda_2 (same clock domain)
//   iTRAIL : 1 = fade trail, 0 = hard on/off
//   oLED   : registered PWM LED drive
//   oFRAME : registered one-cycle pulse at PWM period start
module led_trail_pwm
  import led_pkg::*;
#(
  parameter int N_LED      = 8,
  parameter int PWM_BITS   = DEFAULT_PWM_BITS,
  parameter int DECAY_DIV  = DEFAULT_DECAY_DIV,
  parameter int DECAY_STEP = DEFAULT_DECAY_STEP
) (
  input  logic             iCLK,
  input  logic             iRST_N,
  input  logic [N_LED-1:0] iLED,
  input  logic             iTRAIL,
  output logic [N_LED-1:0] oLED,
  output logic             oFRAME
);

  localparam logic [PWM_BITS-1:0] PWM_LAST = PWM_BITS'(pwm_max(PWM_BITS) - 1);
  localparam int                  PRESC_W  = (DECAY_DIV > 1) ? $clog2(DECAY_DIV) : 1;
  localparam logic [PRESC_W-1:0]  PRESC_LAST = PRESC_W'(DECAY_DIV - 1);

  logic [N_LED-1:0]    led_q;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic [PRESC_W-1:0]  presc;
  logic                tick;

  // The source shares our clock, so a single register is enough.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      led_q <= '0;
    end else begin
      led_q <= iLED;
    end
  end

  // PWM period is PWM_MAX cycles so that full brightness is solid on.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      pwm_cnt <= '0;
      oFRAME  <= 1'b0;
    end else begin
      pwm_cnt <= (pwm_cnt == PWM_LAST) ? '0 : pwm_cnt + 1'b1;
      oFRAME  <= (pwm_cnt == '0);
    end
  end

  // Free-running decay prescaler shared by every channel.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      presc <= '0;
    end else begin
      presc <= (presc == PRESC_LAST) ? '0 : presc + 1'b1;
    end
  end

  assign tick = (presc == PRESC_LAST);

  for (genvar i = 0; i < N_LED; i++) begin : g_chan
    led_fade_channel #(
      .PWM_BITS   (PWM_BITS),
      .DECAY_STEP (DECAY_STEP)
    ) u_chan (
      .clk     (iCLK),
      .rst_n   (iRST_N),
      .led     (led_q[i]),
      .trail   (iTRAIL),
      .tick    (tick),
      .pwm_cnt (pwm_cnt),
      .pwm_out (oLED[i])
    );
  end

endmodule

// File: tb/tb_led_trail_pwm.sv
// tb_led_trail_pwm: directed and randomized bench for led_trail_pwm using a
// behavioural brightness model (PWM_MAX=15, 4-cycle decay tick, step 4).
module tb_led_trail_pwm;

  localparam int PMAX  = 15;
  localparam int DIV   = 4;
  localparam int STEP  = 4;

  logic       iCLK = 1'b0;
  logic       iRST_N;
  logic [7:0] iLED;
  logic       iTRAIL;
  logic [7:0] oLED;
  logic       oFRAME;

  int checks   = 0;
  int failures = 0;

  // Model state: brightness per LED, whether it is in its trail, counters.
  int         m_b[8];
  bit         m_fading[8];
  logic [7:0] m_led_q;
  int         m_pwm;
  int         m_presc;
  logic [7:0] m_exp_led;
  logic       m_exp_frame;

  led_trail_pwm #(
    .N_LED      (8),
    .PWM_BITS   (4),
    .DECAY_DIV  (DIV),
    .DECAY_STEP (STEP)
  ) dut (
    .iCLK   (iCLK),
    .iRST_N (iRST_N),
    .iLED   (iLED),
    .iTRAIL (iTRAIL),
    .oLED   (oLED),
    .oFRAME (oFRAME)
  );

  always #10 iCLK = ~iCLK;

  task automatic modelReset();
    for (int i = 0; i < 8; i++) begin
      m_b[i]      = 0;
      m_fading[i] = 1'b0;
    end
    m_led_q     = '0;
    m_pwm       = 0;
    m_presc     = 0;
    m_exp_led   = '0;
    m_exp_frame = 1'b0;
  endtask

  // One rising edge of the model, using the inputs held before the edge.
  task automatic modelEdge();
    bit tick;
    tick = (m_presc == DIV - 1);
    for (int i = 0; i < 8; i++) m_exp_led[i] = (m_pwm < m_b[i]);
    m_exp_frame = (m_pwm == 0);
    for (int i = 0; i < 8; i++) begin
      if (m_led_q[i]) begin
        m_b[i] = PMAX;
        m_fading[i] = 1'b0;
      end else if (!iTRAIL) begin
        m_b[i] = 0;
        m_fading[i] = 1'b0;
      end else if (!m_fading[i] && m_b[i] == PMAX) begin
        m_fading[i] = 1'b1;
      end else if (m_fading[i] && tick) begin
        if (m_b[i] - STEP > 0) begin
          m_b[i] = m_b[i] - STEP;
        end else begin
          m_b[i] = 0;
          m_fading[i] = 1'b0;
        end
      end
    end
    m_led_q = iLED;
    m_pwm   = (m_pwm + 1) % PMAX;
    m_presc = (m_presc + 1) % DIV;
  endtask

  task automatic checkOutput(input string tag);
    checks++;
    assert (oLED === m_exp_led) else begin
      failures++;
      $error("[TB] FAIL %s oLED=%h expected=%h", tag, oLED, m_exp_led);
    end
    checks++;
    assert (oFRAME === m_exp_frame) else begin
      failures++;
      $error("[TB] FAIL %s_frame oFRAME=%b expected=%b", tag, oFRAME, m_exp_frame);
    end
  endtask

  task automatic checkBits(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("[TB] FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] led, input logic trail);
    iLED   = led;
    iTRAIL = trail;
  endtask

  // Advance one clock, update the model and compare just after the edge.
  task automatic step(input string tag);
    @(posedge iCLK);
    if (!iRST_N) modelReset();
    else         modelEdge();
    #1;
    checkOutput(tag);
  endtask

  initial begin
    bit reached;
    iRST_N = 1'b0;
    applyStimulus(8'hFF, 1'b1);
    modelReset();

    // Reset held with all inputs high.
    #5;
    checkBits("reset_led", oLED, 8'h00);
    checkBits("reset_frame", {7'd0, oFRAME}, 8'h00);
    for (int k = 0; k < 3; k++) begin
      step("in_reset");
      checkBits("in_reset_led", oLED, 8'h00);
    end
    #4 iRST_N = 1'b1;
    step("release_e1");
    step("release_e2");
    checkBits("release_e2_led", oLED, 8'h00);
    step("release_e3");
    checkBits("release_e3_led", oLED, 8'hFF);
    for (int k = 0; k < 30; k++) step("frames");

    // Steady on for LED 0 only.
    applyStimulus(8'h01, 1'b1);
    for (int k = 0; k < 22; k++) step("steady");
    checkBits("steady_led", oLED, 8'h01);

    // Trail fade of LED 0, then fully dark for a whole frame.
    applyStimulus(8'h00, 1'b1);
    for (int k = 0; k < 22; k++) step("fade");
    for (int k = 0; k < 15; k++) begin
      step("fade_done");
      checkBits("fade_done_led", oLED, 8'h00);
    end

    // Hard mode on LED 7.
    applyStimulus(8'h80, 1'b0);
    for (int k = 0; k < 5; k++) step("hard_on");
    applyStimulus(8'h00, 1'b0);
    step("hard_e1");
    step("hard_e2");
    checkBits("hard_e2_led", oLED, 8'h80);
    step("hard_e3");
    checkBits("hard_e3_led", oLED, 8'h00);
    for (int k = 0; k < 15; k++) step("hard_off");

    // Retrigger LED 0 while its trail sits at brightness 7.
    applyStimulus(8'h01, 1'b1);
    for (int k = 0; k < 4; k++) step("retrig_on");
    applyStimulus(8'h00, 1'b1);
    reached = 1'b0;
    for (int k = 0; k < 40 && !reached; k++) begin
      step("retrig_wait");
      reached = (m_b[0] == 7);
    end
    checks++;
    assert (reached) else begin
      failures++;
      $error("[TB] FAIL retrig_timeout reached=%b expected=1", reached);
    end
    applyStimulus(8'h01, 1'b1);
    step("retrig_e1");
    step("retrig_e2");
    for (int k = 0; k < 15; k++) begin
      step("retrig_solid");
      checkBits("retrig_solid_led", oLED, 8'h01);
    end
    applyStimulus(8'h00, 1'b1);
    for (int k = 0; k < 30; k++) step("refade");

    // Asynchronous reset in the middle of a fade.
    applyStimulus(8'h01, 1'b1);
    for (int k = 0; k < 5; k++) step("mid_on");
    applyStimulus(8'h00, 1'b1);
    for (int k = 0; k < 8; k++) step("mid_fade");
    #8 iRST_N = 1'b0;
    #1;
    checkBits("async_led", oLED, 8'h00);
    checkBits("async_frame", {7'd0, oFRAME}, 8'h00);
    modelReset();
    #5 iRST_N = 1'b1;
    for (int k = 0; k < 20; k++) begin
      step("post_reset");
      checkBits("post_reset_led", oLED, 8'h00);
    end

    // Randomized patterns with occasional trail-mode changes.
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 15) == 0) iTRAIL = ~iTRAIL;
      if ($urandom_range(0, 3) == 0) iLED = 8'($urandom);
      step("random");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
